// File: rtl/image_display_pkg.sv
// Shared types and the pixel-format decoder for the image window compositor.
package image_display_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY   = 2'd0,
    MODE_RGB332 = 2'd1,
    MODE_KEY    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Decodes one stored byte into a 12-bit colour; bg covers keyed and reserved cases.
  function automatic rgb12_t pix_to_rgb12(input logic [7:0] d, input mode_e m, input rgb12_t bg);
    rgb12_t c;
    c = bg;
    case (m)
      MODE_GRAY:   c = {d[7:4], d[7:4], d[7:4]};
      MODE_RGB332: c = {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
      MODE_KEY:    c = (d == 8'h00) ? bg : {d[7:4], d[7:4], d[7:4]};
      default:     c = bg;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Reset-to-zero shift register used to carry sideband bits across the memory latency.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/image_window_display.sv
// Places an upscaled frame-buffer image in a movable window on the raster and
// aligns decoded colour with delayed syncs across the BRAM read latency.
module image_window_display
  import image_display_pkg::*;
#(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              visible,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_we,
  input  logic [1:0]        mode,
  input  logic [11:0]       bg_color,
  input  logic [7:0]        image_data,
  output logic [ADDR_W-1:0] image_addr,
  output logic              image_rd,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_start
);

  localparam int          DLY   = MEM_LATENCY + 1;
  localparam int          SB_W  = 6;
  localparam logic [10:0] WIN_W = 11'(IMG_W << SCALE_SHIFT);
  localparam logic [10:0] WIN_H = 11'(IMG_H << SCALE_SHIFT);

  logic [9:0]  r_pend_x, r_pend_y, r_ox, r_oy;
  logic [1:0]  r_pend_mode, r_amode;
  logic        r_pending;

  logic        w_load, w_in_win, w_fetch;
  logic [9:0]  w_ox, w_oy;
  logic [1:0]  w_amode;
  logic [10:0] w_rx, w_ry;
  logic [31:0] w_addr;

  logic [SB_W-1:0] w_sb;
  logic        w_d_hs, w_d_vs, w_d_vis, w_d_win;
  logic [1:0]  w_d_mode;
  rgb12_t      w_pix, w_rgb;

  // Pixel (0,0) already uses the newly loaded origin/mode, so a frame never mixes settings.
  assign w_load  = r_pending && (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign w_ox    = w_load ? r_pend_x    : r_ox;
  assign w_oy    = w_load ? r_pend_y    : r_oy;
  assign w_amode = w_load ? r_pend_mode : r_amode;

  // 11-bit compare keeps windows that run past the right edge from wrapping.
  assign w_rx     = {1'b0, h_cnt} - {1'b0, w_ox};
  assign w_ry     = {1'b0, v_cnt} - {1'b0, w_oy};
  assign w_in_win = (h_cnt >= w_ox) && (v_cnt >= w_oy) && (w_rx < WIN_W) && (w_ry < WIN_H);
  assign w_fetch  = w_in_win && visible;
  assign w_addr   = 32'(w_ry >> SCALE_SHIFT) * 32'(IMG_W) + 32'(w_rx >> SCALE_SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_mode <= '0;
      r_pending   <= 1'b0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_amode     <= '0;
    end else begin
      if (pos_we) begin
        r_pend_x    <= pos_x;
        r_pend_y    <= pos_y;
        r_pend_mode <= mode;
        r_pending   <= 1'b1;
      end else if (w_load) begin
        r_pending   <= 1'b0;
      end
      if (w_load) begin
        r_ox    <= r_pend_x;
        r_oy    <= r_pend_y;
        r_amode <= r_pend_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      image_addr  <= '0;
      image_rd    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      image_addr  <= w_fetch ? w_addr[ADDR_W-1:0] : '0;
      image_rd    <= w_fetch;
      frame_start <= w_load;
    end
  end

  pipe_delay #(.WIDTH(SB_W), .DEPTH(DLY)) u_sideband (
    .clk (clk),
    .rst (rst),
    .i_d ({hsync, vsync, visible, w_in_win, w_amode}),
    .o_q (w_sb)
  );

  assign {w_d_hs, w_d_vs, w_d_vis, w_d_win, w_d_mode} = w_sb;

  always_comb begin
    w_pix = pix_to_rgb12(image_data, mode_e'(w_d_mode), rgb12_t'(bg_color));
    w_rgb = '0;
    if (w_d_vis) w_rgb = w_d_win ? w_pix : rgb12_t'(bg_color);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
    end else begin
      vga_r     <= w_rgb.r;
      vga_g     <= w_rgb.g;
      vga_b     <= w_rgb.b;
      vga_hsync <= w_d_hs;
      vga_vsync <= w_d_vs;
    end
  end

endmodule

// File: tb/tb_image_window_display.sv
// Bench for image_window_display: two instances (memory latency 1 and 3) share stimulus
// and are checked against a frame-level reference model plus a table of fixed vectors.
module tb_image_window_display;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int S     = 1;
  localparam int NPIX  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  h_cnt = '0, v_cnt = '0, pos_x = '0, pos_y = '0;
  logic        visible = 1'b0, hsync = 1'b0, vsync = 1'b0, pos_we = 1'b0;
  logic [1:0]  mode = '0;
  logic [11:0] bg_color = '0;

  logic [7:0]  d1, d3;
  logic [7:0]  d3p [3];
  logic [16:0] a1, a3;
  logic        rd1, rd3, hs1, hs3, vs1, vs3, fs1, fs3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;

  always #5 clk = ~clk;

  image_window_display #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
    .hsync(hsync), .vsync(vsync), .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we),
    .mode(mode), .bg_color(bg_color), .image_data(d1), .image_addr(a1), .image_rd(rd1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hsync(hs1), .vga_vsync(vs1), .frame_start(fs1));

  image_window_display #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
    .hsync(hsync), .vsync(vsync), .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we),
    .mode(mode), .bg_color(bg_color), .image_data(d3), .image_addr(a3), .image_rd(rd3),
    .vga_r(r3), .vga_g(g3), .vga_b(b3), .vga_hsync(hs3), .vga_vsync(vs3), .frame_start(fs3));

  // Frame buffer: either a constant byte or a random image.
  logic [7:0] mem [NPIX];
  bit         const_en = 1'b1;
  logic [7:0] const_d = 8'h00;

  function automatic logic [7:0] memrd(input int a);
    if (const_en) return const_d;
    if (a < NPIX) return mem[a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    d1     <= memrd(int'(a1));
    d3p[0] <= memrd(int'(a3));
    d3p[1] <= d3p[0];
    d3p[2] <= d3p[1];
  end
  assign d3 = d3p[2];

  typedef struct packed {
    logic [16:0] addr;
    logic        rd;
    logic        fs;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t ring [16];
  int   cyc = 16;
  int   nchk = 0, nerr = 0;
  bit   in_rst = 1'b0;

  // Reference model state: pending and active window settings.
  int pox = 0, poy = 0, pmd = 0, aox = 0, aoy = 0, amd = 0;
  bit pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] colour(input int d, input int md, input logic [11:0] bg);
    int r, g, b;
    case (md)
      0: begin r = d / 16; g = r; b = r; end
      1: begin r = (d / 32) * 2 + d / 128; g = ((d / 4) % 8) * 2 + (d / 16) % 2; b = (d % 4) * 5; end
      2: begin
        if (d == 0) return bg;
        r = d / 16; g = r; b = r;
      end
      default: return bg;
    endcase
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic drive(input int h, input int v, input bit vis, input bit hs, input bit vs,
                       input bit we, input int px, input int py, input int md);
    exp_t e;
    bit load, inwin;
    int rx, ry;
    exp_t ea, e1, e3;
    @(posedge clk); #1;
    h_cnt = 10'(h); v_cnt = 10'(v); visible = vis; hsync = hs; vsync = vs;
    pos_we = we; pos_x = 10'(px); pos_y = 10'(py); mode = 2'(md);
    e = '0;
    if (!in_rst) begin
      load = pend && h == 0 && v == 0;
      if (load) begin aox = pox; aoy = poy; amd = pmd; end
      if (we) begin pox = px; poy = py; pmd = md; pend = 1'b1; end
      else if (load) pend = 1'b0;
      rx = h - aox;
      ry = v - aoy;
      inwin = rx >= 0 && ry >= 0 && rx < (IMG_W << S) && ry < (IMG_H << S);
      e.fs = load; e.hs = hs; e.vs = vs;
      if (vis && inwin) begin
        e.rd   = 1'b1;
        e.addr = 17'((ry >> S) * IMG_W + (rx >> S));
        e.rgb  = colour(int'(memrd(int'(e.addr))), amd, bg_color);
      end else if (vis) begin
        e.rgb = bg_color;
      end
    end
    ring[cyc % 16] = e;
    @(negedge clk);
    ea = ring[(cyc - 1) % 16];
    e1 = ring[(cyc - 3) % 16];
    e3 = ring[(cyc - 5) % 16];
    chk("lat1_addr", {a1, rd1, fs1}, {ea.addr, ea.rd, ea.fs});
    chk("lat1_pix",  {r1, g1, b1, hs1, vs1}, {e1.rgb, e1.hs, e1.vs});
    chk("lat3_addr", {a3, rd3, fs3}, {ea.addr, ea.rd, ea.fs});
    chk("lat3_pix",  {r3, g3, b3, hs3, vs3}, {e3.rgb, e3.hs, e3.vs});
    cyc++;
  endtask

  task automatic idle();
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic flush();
    repeat (6) idle();
  endtask

  task automatic set_win(input int px, input int py, input int md);
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b1, px, py, md);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  typedef struct {
    int          px, py, md;
    logic [11:0] bg;
    logic [7:0]  d;
    int          h, v;
    bit          vis;
    logic [16:0] eaddr;
    bit          erd;
    logic [11:0] ergb;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{0,   0,  0, 12'h000, 8'hA5,   5,   3, 1'b1, 17'd322,   1'b1, 12'hAAA};
    tbl[1]  = '{0,   0,  1, 12'h000, 8'hB9,   5,   3, 1'b1, 17'd322,   1'b1, 12'hBD5};
    tbl[2]  = '{0,   0,  2, 12'h0F0, 8'h00,   5,   3, 1'b1, 17'd322,   1'b1, 12'h0F0};
    tbl[3]  = '{0,   0,  2, 12'h0F0, 8'h37,   5,   3, 1'b1, 17'd322,   1'b1, 12'h333};
    tbl[4]  = '{0,   0,  3, 12'h123, 8'hA5,   5,   3, 1'b1, 17'd322,   1'b1, 12'h123};
    tbl[5]  = '{0,   0,  1, 12'h000, 8'h24,   5,   3, 1'b1, 17'd322,   1'b1, 12'h220};
    tbl[6]  = '{0,   0,  0, 12'h000, 8'hA5,   5,   3, 1'b0, 17'd0,     1'b0, 12'h000};
    tbl[7]  = '{100, 50, 0, 12'h456, 8'hA5,  99,  60, 1'b1, 17'd0,     1'b0, 12'h456};
    tbl[8]  = '{100, 50, 0, 12'h456, 8'hA5, 100,  50, 1'b1, 17'd0,     1'b1, 12'hAAA};
    tbl[9]  = '{100, 50, 0, 12'h456, 8'hA5, 101,  50, 1'b1, 17'd0,     1'b1, 12'hAAA};
    tbl[10] = '{100, 50, 0, 12'h456, 8'hA5, 102,  51, 1'b1, 17'd1,     1'b1, 12'hAAA};
    tbl[11] = '{100, 50, 0, 12'h456, 8'hA5, 639,  52, 1'b1, 17'd589,   1'b1, 12'hAAA};
    tbl[12] = '{600, 0,  0, 12'h456, 8'hA5, 599,   1, 1'b1, 17'd0,     1'b0, 12'h456};
    tbl[13] = '{600, 0,  0, 12'h456, 8'hA5, 600,   1, 1'b1, 17'd0,     1'b1, 12'hAAA};
    tbl[14] = '{600, 0,  0, 12'h456, 8'hA5, 639, 479, 1'b1, 17'd76499, 1'b1, 12'hAAA};
    tbl[15] = '{600, 0,  0, 12'h456, 8'hA5,   0,  10, 1'b1, 17'd0,     1'b0, 12'h456};

    for (int i = 0; i < 16; i++) ring[i] = '0;

    // Power-on reset: every output must read zero.
    #2 rst_n = 1'b0;
    in_rst = 1'b1;
    repeat (3) idle();
    chk("reset_state", {a1, rd1, fs1, r1, g1, b1, hs1, vs1, a3, rd3, fs3, r3, g3, b3, hs3, vs3}, '0);
    rst_n = 1'b1;
    in_rst = 1'b0;
    flush();

    // Fixed vectors.
    for (int i = 0; i < 16; i++) begin
      flush();
      const_en = 1'b1; const_d = tbl[i].d; bg_color = tbl[i].bg;
      set_win(tbl[i].px, tbl[i].py, tbl[i].md);
      drive(tbl[i].h, tbl[i].v, tbl[i].vis, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      idle();
      chk($sformatf("tbl%0d_addr", i), {a1, rd1, a3, rd3}, {tbl[i].eaddr, tbl[i].erd, tbl[i].eaddr, tbl[i].erd});
      idle(); idle();
      chk($sformatf("tbl%0d_rgb1", i), {r1, g1, b1}, tbl[i].ergb);
      idle(); idle();
      chk($sformatf("tbl%0d_rgb3", i), {r3, g3, b3}, tbl[i].ergb);
    end

    // Mid-frame position write is deferred to the next frame start.
    flush();
    const_d = 8'hA5; bg_color = 12'h456;
    set_win(0, 0, 0);
    idle();
    chk("fs_pulse", fs1, 1);
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b1, 100, 50, 0);
    drive(5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("no_tear", {a1, rd1, fs1}, {17'd322, 1'b1, 1'b0});
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("fs_moved", fs1, 1);
    drive(5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("moved_away", {a1, rd1}, {17'd0, 1'b0});
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("fs_none", fs3, 0);

    // Write coinciding with frame start: old pending loads, new one waits a frame.
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b1, 200, 0, 0);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 0, 1);
    idle();
    chk("fs_coinc", fs1, 1);
    drive(200, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("old_pending", {a1, rd1}, {17'd0, 1'b1});
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("fs_next", fs1, 1);
    drive(250, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("new_left", rd1, 0);
    drive(300, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("new_origin", {a1, rd1}, {17'd0, 1'b1});

    // hsync pulse travels with the colour of the same pixel.
    flush();
    set_win(0, 0, 0);
    drive(5, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      idle();
      chk($sformatf("hs1_k%0d", k), hs1, (k == 3) ? 1'b1 : 1'b0);
      chk($sformatf("hs3_k%0d", k), {hs3, r3}, (k == 5) ? {1'b1, 4'hA} : {1'b0, 4'h0});
    end

    // Asynchronous reset mid-line with a pending write and pixels in flight.
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b1, 300, 0, 1);
    drive(5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    drive(6, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst1", {a1, rd1, fs1, r1, g1, b1, hs1, vs1}, '0);
    chk("async_rst3", {a3, rd3, fs3, r3, g3, b3, hs3, vs3}, '0);
    in_rst = 1'b1;
    for (int i = 0; i < 16; i++) ring[i] = '0;
    pend = 1'b0; aox = 0; aoy = 0; amd = 0;
    repeat (3) idle();
    rst_n = 1'b1;
    in_rst = 1'b0;
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle();
    chk("pend_cleared", {fs1, fs3}, 2'b00);
    drive(5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      if (k == 4) chk("resume_early", {r3, g3, b3}, 12'h000);
      if (k == 5) chk("resume", {r3, g3, b3}, 12'hAAA);
    end

    // Randomized raster with random image, origins and modes.
    flush();
    for (int i = 0; i < NPIX; i++) mem[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
    const_en = 1'b0;
    bg_color = 12'($urandom);
    flush();
    for (int n = 0; n < 5000; n++) begin
      int h, v, sel;
      sel = $urandom_range(0, 99);
      h = $urandom_range(0, 799);
      v = $urandom_range(0, 524);
      if (sel < 3) begin
        h = 0; v = 0;
      end else if (sel < 30) begin
        h = aox + $urandom_range(0, 4) - 2;
        if (h < 0) h = 0;
        if (h > 799) h = 799;
      end else if (sel < 45) begin
        v = aoy + $urandom_range(0, 4) - 2;
        if (v < 0) v = 0;
        if (v > 524) v = 524;
      end
      drive(h, v, (h < 640 && v < 480), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 39) == 0), $urandom_range(0, 639), $urandom_range(0, 479),
            $urandom_range(0, 3));
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
